pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Drives the load/flush inputs of the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register.
- Sits between the datapath stage outputs and the register loads; it is the controlling end of every register's load port.
- Detects load-use hazards, taken-branch redirects and I/D-cache miss stalls, and inserts bubbles or freezes the pipeline.
- Keeps saturating performance counters for stalls, bubbles and flushes.

Parameters:
- CNT_WIDTH, 32, width of each performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_rs1  in  5  rs1 index of instruction in ID
- id_rs2  in  5  rs2 index of instruction in ID
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- ex_rd  in  5  rd of instruction in EX
- ex_is_load  in  1  EX instruction is a load
- ex_br_taken  in  1  EX resolved a taken branch or jump
- icache_req  in  1  fetch request outstanding
- icache_resp  in  1  fetch data valid this cycle
- dcache_req  in  1  MEM-stage read or write outstanding
- dcache_resp  in  1  MEM-stage access complete this cycle
- load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1 each  register load enables
- flush_if_id, flush_id_ex  out  1 each  replace the register contents with a bubble (all-zero word)
- stall_cnt, bubble_cnt, flush_cnt  out  CNT_WIDTH each  performance counters

Behaviour:
- Clock is clk. Reset is rst, synchronous, active-high.
- Reset: state = RUN; all counters = 0.
- During reset all load outputs = 0 and flush outputs = 0.
- Load and flush outputs are combinational from the current state and inputs.
- State is registered on the rising edge of clk.
- mem_miss = dcache_req & ~dcache_resp.
- fetch_miss = icache_req & ~icache_resp.
- load_use = ex_is_load & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
- States: RUN, MEM_STALL, FETCH_STALL.
  - RUN -> MEM_STALL when mem_miss.
  - RUN -> FETCH_STALL when fetch_miss & ~mem_miss.
  - MEM_STALL -> RUN on dcache_resp & ~fetch_miss.
  - MEM_STALL -> FETCH_STALL on dcache_resp & fetch_miss.
  - FETCH_STALL -> MEM_STALL if mem_miss. A D-miss arising while frozen cannot occur, but the transition is still defined.
  - FETCH_STALL -> RUN on icache_resp.
- Output priority, highest first, evaluated every cycle:
  1. mem_miss or fetch_miss (global freeze): all loads 0, flushes 0.
  2. ex_br_taken: all loads 1; flush_if_id = 1; flush_id_ex = 1. Any simultaneous load_use is ignored because the ID instruction is squashed.
  3. load_use: load_pc = 0; load_if_id = 0; load_id_ex = 1 with flush_id_ex = 1; load_ex_mem = 1; load_mem_wb = 1. This inserts exactly one bubble. The next cycle, EX holds the bubble (ex_is_load = 0), so the hazard does not re-trigger.
  4. Otherwise all loads 1, flushes 0.
- A completion and a new hazard in the same cycle (resp high and load_use high) apply priority 3 in that cycle.
- Counters saturate at all-ones and never wrap.
  - stall_cnt increments on every freeze cycle.
  - bubble_cnt increments on every load_use bubble.
  - flush_cnt increments on every ex_br_taken flush.
- Reset asserted mid-stall returns the block to RUN next cycle and clears the counters. Outputs are 0 while rst is high.
- rd = x0 never causes a hazard.

Decomposition:
- pipe_types package gains hazard_state_t (enum RUN, MEM_STALL, FETCH_STALL) and a hazard_ctrl_t struct bundling the seven load/flush bits, so that the datapath connects one signal.
- One sub-module: hazard_perf_counter (CNT_WIDTH, clk, rst, inc, count), a saturating counter instantiated three times.

Test Plan:
- Reset: hold rst 2 cycles with random inputs -> all outputs 0; after release with no hazards, all loads = 1 and counters = 0.
- Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> load_pc=0, load_if_id=0, flush_id_ex=1 for exactly 1 cycle; bubble_cnt=1. Repeat with ex_rd=0 -> no bubble.
- Branch over load-use: ex_br_taken=1 with the load-use condition also true -> flush_if_id=1, flush_id_ex=1, load_pc=1, bubble_cnt unchanged, flush_cnt=1.
- D-miss: dcache_req=1 with resp low for 4 cycles, then resp=1 -> all loads 0 for 4 cycles, state MEM_STALL, stall_cnt=4, loads = 1 on the resp cycle.
- Back-to-back: dcache_resp and icache_req (resp low) in the same cycle -> state goes directly MEM_STALL -> FETCH_STALL, and the freeze continues without a gap.
- Saturation: CNT_WIDTH=4, hold a D-miss for 20 cycles -> stall_cnt sticks at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding and the
// bundled load/flush control word consumed by the datapath.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    MEM_STALL   = 2'd1,
    FETCH_STALL = 2'd2
  } hazard_state_t;

  typedef struct packed {
    logic load_pc;
    logic load_if_id;
    logic load_id_ex;
    logic load_ex_mem;
    logic load_mem_wb;
    logic flush_if_id;
    logic flush_id_ex;
  } hazard_ctrl_t;

  localparam hazard_ctrl_t CTRL_FREEZE = 7'b00000_00;
  localparam hazard_ctrl_t CTRL_RUN    = 7'b11111_00;
  localparam hazard_ctrl_t CTRL_FLUSH  = 7'b11111_11;
  // Hold PC and IF/ID, load a bubble into ID/EX, let the back end drain.
  localparam hazard_ctrl_t CTRL_BUBBLE = 7'b00111_01;

  function automatic logic src_match(input logic uses, input logic [4:0] rs,
                                     input logic [4:0] rd);
    return uses & (rs == rd);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard sources from the datapath and the register load/flush controls back to it.
interface pipeline_hazard_ctrl_if;
  import pipeline_hazard_ctrl_pkg::*;

  logic [4:0]   id_rs1;
  logic [4:0]   id_rs2;
  logic         id_uses_rs1;
  logic         id_uses_rs2;
  logic [4:0]   ex_rd;
  logic         ex_is_load;
  logic         ex_br_taken;
  logic         icache_req;
  logic         icache_resp;
  logic         dcache_req;
  logic         dcache_resp;
  logic         load_pc;
  logic         load_if_id;
  logic         load_id_ex;
  logic         load_ex_mem;
  logic         load_mem_wb;
  logic         flush_if_id;
  logic         flush_id_ex;
  hazard_ctrl_t ctrl;

  modport master (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_is_load,
           ex_br_taken, icache_req, icache_resp, dcache_req, dcache_resp,
    output load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
           flush_if_id, flush_id_ex, ctrl
  );

  modport slave (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_is_load,
           ex_br_taken, icache_req, icache_resp, dcache_req, dcache_resp,
    input  load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
           flush_if_id, flush_id_ex, ctrl
  );

endinterface

// File: rtl/hazard_perf_counter.sv
// Saturating event counter: sticks at all-ones instead of wrapping.
module hazard_perf_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_WIDTH{1'b1}})) begin
      count <= count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: freezes on cache misses, flushes on taken branches,
// inserts a single bubble on load-use, and counts each event.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_hazard_ctrl_if.master bus,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] bubble_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  hazard_state_t state;
  hazard_state_t state_next;
  hazard_ctrl_t  ctrl;
  logic          mem_miss;
  logic          fetch_miss;
  logic          load_use;
  logic          freeze;
  logic          inc_stall;
  logic          inc_bubble;
  logic          inc_flush;

  assign mem_miss   = bus.dcache_req & ~bus.dcache_resp;
  assign fetch_miss = bus.icache_req & ~bus.icache_resp;
  assign freeze     = mem_miss | fetch_miss;
  assign load_use   = bus.ex_is_load & (bus.ex_rd != 5'd0) &
                      (src_match(bus.id_uses_rs1, bus.id_rs1, bus.ex_rd) |
                       src_match(bus.id_uses_rs2, bus.id_rs2, bus.ex_rd));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      RUN: begin
        if (mem_miss)        state_next = MEM_STALL;
        else if (fetch_miss) state_next = FETCH_STALL;
      end
      MEM_STALL: begin
        if (bus.dcache_resp) state_next = fetch_miss ? FETCH_STALL : RUN;
      end
      FETCH_STALL: begin
        if (mem_miss)             state_next = MEM_STALL;
        else if (bus.icache_resp) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  // Output priority: freeze > branch flush > load-use bubble > normal advance.
  always_comb begin
    ctrl       = CTRL_FREEZE;
    inc_stall  = 1'b0;
    inc_bubble = 1'b0;
    inc_flush  = 1'b0;
    if (!rst) begin
      if (freeze) begin
        ctrl      = CTRL_FREEZE;
        inc_stall = 1'b1;
      end else if (bus.ex_br_taken) begin
        ctrl      = CTRL_FLUSH;
        inc_flush = 1'b1;
      end else if (load_use) begin
        ctrl       = CTRL_BUBBLE;
        inc_bubble = 1'b1;
      end else begin
        ctrl = CTRL_RUN;
      end
    end
  end

  assign bus.ctrl        = ctrl;
  assign bus.load_pc     = ctrl.load_pc;
  assign bus.load_if_id  = ctrl.load_if_id;
  assign bus.load_id_ex  = ctrl.load_id_ex;
  assign bus.load_ex_mem = ctrl.load_ex_mem;
  assign bus.load_mem_wb = ctrl.load_mem_wb;
  assign bus.flush_if_id = ctrl.flush_if_id;
  assign bus.flush_id_ex = ctrl.flush_id_ex;

  hazard_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk(clk), .rst(rst), .inc(inc_stall), .count(stall_cnt)
  );

  hazard_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_bubble_cnt (
    .clk(clk), .rst(rst), .inc(inc_bubble), .count(bubble_cnt)
  );

  hazard_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk(clk), .rst(rst), .inc(inc_flush), .count(flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; a second 4-bit-counter instance covers saturation.
module tb_pipeline_hazard_ctrl;
  import pipeline_hazard_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] stall_cnt, bubble_cnt, flush_cnt;
  logic [3:0]  sat_stall, sat_bubble, sat_flush;
  logic [6:0]  ctl;
  logic [6:0]  sat_ctl;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if bus ();
  pipeline_hazard_ctrl_if sat_bus ();

  pipeline_hazard_ctrl #(.CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .bus(bus.master),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_hazard_ctrl #(.CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst), .bus(sat_bus.master),
    .stall_cnt(sat_stall), .bubble_cnt(sat_bubble), .flush_cnt(sat_flush)
  );

  assign ctl = {bus.load_pc, bus.load_if_id, bus.load_id_ex, bus.load_ex_mem,
                bus.load_mem_wb, bus.flush_if_id, bus.flush_id_ex};
  assign sat_ctl = {sat_bus.load_pc, sat_bus.load_if_id, sat_bus.load_id_ex,
                    sat_bus.load_ex_mem, sat_bus.load_mem_wb,
                    sat_bus.flush_if_id, sat_bus.flush_id_ex};

  task automatic clear_inputs();
    bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0; bus.id_uses_rs1 = 1'b0; bus.id_uses_rs2 = 1'b0;
    bus.ex_rd = 5'd0; bus.ex_is_load = 1'b0; bus.ex_br_taken = 1'b0;
    bus.icache_req = 1'b0; bus.icache_resp = 1'b0; bus.dcache_req = 1'b0; bus.dcache_resp = 1'b0;
    sat_bus.id_rs1 = 5'd0; sat_bus.id_rs2 = 5'd0; sat_bus.id_uses_rs1 = 1'b0;
    sat_bus.id_uses_rs2 = 1'b0; sat_bus.ex_rd = 5'd0; sat_bus.ex_is_load = 1'b0;
    sat_bus.ex_br_taken = 1'b0; sat_bus.icache_req = 1'b0; sat_bus.icache_resp = 1'b0;
    sat_bus.dcache_req = 1'b0; sat_bus.dcache_resp = 1'b0;
  endtask

  // Advance past the next rising edge; inputs change 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    bus.ex_is_load = 1'b1; bus.ex_rd = rd; bus.id_rs1 = 5'd5; bus.id_uses_rs1 = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.id_rs1 = 5'($urandom); bus.id_rs2 = 5'($urandom); bus.ex_rd = 5'($urandom);
      {bus.id_uses_rs1, bus.id_uses_rs2, bus.ex_is_load, bus.ex_br_taken} = 4'($urandom);
      {bus.icache_req, bus.icache_resp, bus.dcache_req, bus.dcache_resp} = 4'($urandom);
      #2;
      checks++;
      if (ctl !== 7'b0) begin
        errors++; $display("FAIL reset_outputs cycle %0d got %b want 0000000", i, ctl);
      end
      tick();
    end
    clear_inputs();
    rst = 1'b0;
    #2;
    checks++;
    if (ctl !== 7'b1111100) begin
      errors++; $display("FAIL post_reset_loads got %b want 1111100", ctl);
    end
    checks++;
    if ({stall_cnt, bubble_cnt, flush_cnt} !== 96'd0) begin
      errors++; $display("FAIL post_reset_counters got %0d/%0d/%0d want 0/0/0",
                         stall_cnt, bubble_cnt, flush_cnt);
    end
    checks++;
    if (dut.state !== RUN) begin
      errors++; $display("FAIL post_reset_state got %0d want %0d", dut.state, RUN);
    end
    tick();
  endtask

  task automatic test_load_use();
    set_load_use(5'd5);
    #2;
    checks++;
    if (ctl !== 7'b0011101) begin
      errors++; $display("FAIL load_use_ctl got %b want 0011101", ctl);
    end
    tick();
    bus.ex_is_load = 1'b0;
    #2;
    checks++;
    if (ctl !== 7'b1111100) begin
      errors++; $display("FAIL load_use_one_cycle got %b want 1111100", ctl);
    end
    checks++;
    if (bubble_cnt !== 32'd1) begin
      errors++; $display("FAIL bubble_cnt_1 got %0d want 1", bubble_cnt);
    end
    tick();
    set_load_use(5'd0);
    bus.id_rs1 = 5'd0;
    #2;
    checks++;
    if (ctl !== 7'b1111100) begin
      errors++; $display("FAIL x0_no_hazard got %b want 1111100", ctl);
    end
    tick();
    clear_inputs();
    #2;
    checks++;
    if (bubble_cnt !== 32'd1) begin
      errors++; $display("FAIL x0_bubble_cnt got %0d want 1", bubble_cnt);
    end
  endtask

  task automatic test_branch_over_load_use();
    set_load_use(5'd5);
    bus.ex_br_taken = 1'b1;
    #2;
    checks++;
    if (ctl !== 7'b1111111) begin
      errors++; $display("FAIL branch_ctl got %b want 1111111", ctl);
    end
    tick();
    clear_inputs();
    #2;
    checks++;
    if ({flush_cnt, bubble_cnt} !== {32'd1, 32'd1}) begin
      errors++; $display("FAIL branch_counters flush %0d bubble %0d want 1 1", flush_cnt, bubble_cnt);
    end
  endtask

  task automatic test_dmiss();
    bus.dcache_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      checks++;
      if (ctl !== 7'b0) begin
        errors++; $display("FAIL dmiss_freeze cycle %0d got %b want 0000000", i, ctl);
      end
      tick();
      checks++;
      if (dut.state !== MEM_STALL) begin
        errors++; $display("FAIL dmiss_state cycle %0d got %0d want %0d", i, dut.state, MEM_STALL);
      end
    end
    checks++;
    if (stall_cnt !== 32'd4) begin
      errors++; $display("FAIL dmiss_stall_cnt got %0d want 4", stall_cnt);
    end
    bus.dcache_resp = 1'b1;
    #2;
    checks++;
    if (ctl !== 7'b1111100) begin
      errors++; $display("FAIL dmiss_resp_loads got %b want 1111100", ctl);
    end
    tick();
    clear_inputs();
    #2;
    checks++;
    if ({dut.state, stall_cnt} !== {RUN, 32'd4}) begin
      errors++; $display("FAIL dmiss_done state %0d stall %0d want %0d 4", dut.state, stall_cnt, RUN);
    end
  endtask

  task automatic test_back_to_back();
    bus.dcache_req = 1'b1;
    tick();
    bus.dcache_resp = 1'b1; bus.icache_req = 1'b1;
    #2;
    checks++;
    if (ctl !== 7'b0) begin
      errors++; $display("FAIL b2b_handover got %b want 0000000", ctl);
    end
    tick();
    checks++;
    if (dut.state !== FETCH_STALL) begin
      errors++; $display("FAIL b2b_state got %0d want %0d", dut.state, FETCH_STALL);
    end
    bus.dcache_req = 1'b0; bus.dcache_resp = 1'b0;
    #2;
    checks++;
    if (ctl !== 7'b0) begin
      errors++; $display("FAIL b2b_fetch_freeze got %b want 0000000", ctl);
    end
    tick();
    bus.icache_resp = 1'b1;
    #2;
    checks++;
    if (ctl !== 7'b1111100) begin
      errors++; $display("FAIL b2b_fetch_resp got %b want 1111100", ctl);
    end
    tick();
    clear_inputs();
    #2;
    checks++;
    if ({dut.state, stall_cnt} !== {RUN, 32'd7}) begin
      errors++; $display("FAIL b2b_done state %0d stall %0d want %0d 7", dut.state, stall_cnt, RUN);
    end
  endtask

  task automatic test_resp_with_hazard();
    bus.dcache_req = 1'b1;
    tick();
    bus.dcache_resp = 1'b1;
    set_load_use(5'd5);
    #2;
    checks++;
    if (ctl !== 7'b0011101) begin
      errors++; $display("FAIL resp_hazard_ctl got %b want 0011101", ctl);
    end
    tick();
    clear_inputs();
    #2;
    checks++;
    if ({dut.state, stall_cnt, bubble_cnt} !== {RUN, 32'd8, 32'd2}) begin
      errors++; $display("FAIL resp_hazard_done state %0d stall %0d bubble %0d want %0d 8 2",
                         dut.state, stall_cnt, bubble_cnt, RUN);
    end
  endtask

  task automatic test_saturation();
    sat_bus.dcache_req = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    #2;
    checks++;
    if (sat_stall !== 4'd15) begin
      errors++; $display("FAIL sat_stall_cnt got %0d want 15", sat_stall);
    end
    checks++;
    if (sat_ctl !== 7'b0) begin
      errors++; $display("FAIL sat_freeze got %b want 0000000", sat_ctl);
    end
  endtask

  task automatic test_reset_mid_stall();
    bus.dcache_req = 1'b1;
    tick();
    checks++;
    if ({dut.state, stall_cnt} !== {MEM_STALL, 32'd9}) begin
      errors++; $display("FAIL mid_stall_pre state %0d stall %0d want %0d 9", dut.state, stall_cnt, MEM_STALL);
    end
    rst = 1'b1;
    #2;
    checks++;
    if (ctl !== 7'b0) begin
      errors++; $display("FAIL mid_stall_rst_out got %b want 0000000", ctl);
    end
    tick();
    rst = 1'b0;
    clear_inputs();
    #2;
    checks++;
    if ({dut.state, stall_cnt, bubble_cnt, flush_cnt, sat_stall} !== {RUN, 96'd0, 4'd0}) begin
      errors++; $display("FAIL mid_stall_cleared state %0d stall %0d bubble %0d flush %0d sat %0d",
                         dut.state, stall_cnt, bubble_cnt, flush_cnt, sat_stall);
    end
    checks++;
    if (ctl !== 7'b1111100) begin
      errors++; $display("FAIL mid_stall_resume got %b want 1111100", ctl);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_over_load_use();
    test_dmiss();
    test_back_to_back();
    test_resp_with_hazard();
    test_saturation();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
